// File: rtl/wavegen_cfg_pkg.sv
// rtl/wavegen_cfg_pkg.sv - shared encodings for the wavegen configuration controller
package wavegen_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DHI,
      ST_DLO,
      ST_CSUM,
      ST_CHECK,
      ST_RESP
   } state_t;

   localparam logic [7:0] HDR = 8'hA5;
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   localparam logic [3:0] REG_STEP       = 4'd0;
   localparam logic [3:0] REG_INIT       = 4'd1;
   localparam logic [3:0] REG_OFFSET     = 4'd2;
   localparam logic [3:0] REG_PRESCALER  = 4'd3;
   localparam logic [3:0] REG_WAVESEL    = 4'd4;
   localparam logic [3:0] REG_EN         = 4'd5;
   localparam logic [3:0] REG_COMMIT     = 4'd6;
   localparam logic [3:0] REG_COMMIT_ALL = 4'd7;

   function automatic logic addr_legal(input logic [7:0] addr);
      return (addr[6:4] == 3'd0) && (addr[3:0] <= REG_COMMIT_ALL);
   endfunction

endpackage

// File: rtl/wavegen_cfg_bank.sv
// rtl/wavegen_cfg_bank.sv - one channel's shadow and active register set
module wavegen_cfg_bank
   import wavegen_cfg_pkg::*;
#(
   parameter int PW = 16,
   parameter int VW = 16,
   parameter int DW = 5,
   parameter int OW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [3:0]    wr_idx,
   input  logic [15:0]   wr_data,
   input  logic          commit,
   output logic [PW-1:0] step,
   output logic [VW-1:0] init,
   output logic [OW-1:0] offset,
   output logic [DW-1:0] prescaler,
   output logic [1:0]    wavesel,
   output logic          en
);

   logic [PW-1:0] sh_step;
   logic [VW-1:0] sh_init;
   logic [OW-1:0] sh_offset;
   logic [DW-1:0] sh_prescaler;
   logic [1:0]    sh_wavesel;
   logic          sh_en;

   logic unused_data_bits;
   assign unused_data_bits = ^wr_data;

   // Active set is copied in a single edge so the wavegen never sees a mix
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_step      <= '0;
         sh_init      <= '0;
         sh_offset    <= '0;
         sh_prescaler <= '0;
         sh_wavesel   <= '0;
         sh_en        <= 1'b0;
         step         <= '0;
         init         <= '0;
         offset       <= '0;
         prescaler    <= '0;
         wavesel      <= '0;
         en           <= 1'b0;
      end else begin
         if (wr_en) begin
            case (wr_idx)
               REG_STEP:      sh_step      <= wr_data[PW-1:0];
               REG_INIT:      sh_init      <= wr_data[VW-1:0];
               REG_OFFSET:    sh_offset    <= wr_data[OW-1:0];
               REG_PRESCALER: sh_prescaler <= wr_data[DW-1:0];
               REG_WAVESEL:   sh_wavesel   <= wr_data[1:0];
               REG_EN:        sh_en        <= wr_data[0];
               default:       ;
            endcase
         end
         if (commit) begin
            step      <= sh_step;
            init      <= sh_init;
            offset    <= sh_offset;
            prescaler <= sh_prescaler;
            wavesel   <= sh_wavesel;
            en        <= sh_en;
         end
      end
   end

endmodule

// File: rtl/wavegen_cfg_ctrl.sv
// rtl/wavegen_cfg_ctrl.sv - framed byte command parser driving two wavegen register banks
module wavegen_cfg_ctrl
   import wavegen_cfg_pkg::*;
#(
   parameter int PW      = 16,
   parameter int VW      = 16,
   parameter int DW      = 5,
   parameter int OW      = 12,
   parameter int TO_W    = 20,
   parameter int TIMEOUT = 100000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   output logic [7:0]    tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic [PW-1:0] step_ch1,
   output logic [PW-1:0] step_ch2,
   output logic [VW-1:0] init_ch1,
   output logic [VW-1:0] init_ch2,
   output logic [OW-1:0] offset_ch1,
   output logic [OW-1:0] offset_ch2,
   output logic [DW-1:0] prescaler_ch1,
   output logic [DW-1:0] prescaler_ch2,
   output logic [1:0]    wavesel_ch1,
   output logic [1:0]    wavesel_ch2,
   output logic          ch1_en,
   output logic          ch2_en,
   output logic [1:0]    commit_pulse,
   output logic [7:0]    err_count
);

   state_t          state;
   logic [7:0]      addr_q, dhi_q, dlo_q, csum_q;
   logic [TO_W-1:0] to_cnt;

   logic       accept, in_frame, good, timeout_hit, err_inc;
   logic       in_check, is_write, commit1, commit2;
   logic [3:0] idx;

   assign in_frame = (state == ST_ADDR) || (state == ST_DHI) ||
                     (state == ST_DLO)  || (state == ST_CSUM);
   assign rx_ready = rst_n && ((state == ST_IDLE) || in_frame);
   assign accept   = rx_valid && rx_ready;

   assign idx         = addr_q[3:0];
   assign good        = addr_legal(addr_q) && (csum_q == (addr_q ^ dhi_q ^ dlo_q));
   assign in_check    = (state == ST_CHECK);
   assign is_write    = in_check && good && (idx <= REG_EN);
   assign commit1     = in_check && good && ((idx == REG_COMMIT_ALL) ||
                                             (idx == REG_COMMIT && !addr_q[7]));
   assign commit2     = in_check && good && ((idx == REG_COMMIT_ALL) ||
                                             (idx == REG_COMMIT && addr_q[7]));
   assign timeout_hit = in_frame && !accept && (to_cnt == TO_W'(TIMEOUT - 1));
   assign err_inc     = (in_check && !good) || timeout_hit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         addr_q       <= '0;
         dhi_q        <= '0;
         dlo_q        <= '0;
         csum_q       <= '0;
         to_cnt       <= '0;
         tx_data      <= '0;
         tx_valid     <= 1'b0;
         commit_pulse <= '0;
         err_count    <= '0;
      end else begin
         commit_pulse <= {commit2, commit1};
         if (err_inc && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
         case (state)
            ST_IDLE: begin
               to_cnt <= '0;
               if (accept && (rx_data == HDR))
                  state <= ST_ADDR;
            end
            ST_ADDR, ST_DHI, ST_DLO, ST_CSUM: begin
               if (accept) begin
                  to_cnt <= '0;
                  case (state)
                     ST_ADDR: begin addr_q <= rx_data; state <= ST_DHI;   end
                     ST_DHI:  begin dhi_q  <= rx_data; state <= ST_DLO;   end
                     ST_DLO:  begin dlo_q  <= rx_data; state <= ST_CSUM;  end
                     default: begin csum_q <= rx_data; state <= ST_CHECK; end
                  endcase
               end else if (timeout_hit) begin
                  to_cnt <= '0;
                  state  <= ST_IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            ST_CHECK: begin
               tx_valid <= 1'b1;
               tx_data  <= good ? ACK : NAK;
               state    <= ST_RESP;
            end
            ST_RESP: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   wavegen_cfg_bank #(.PW(PW), .VW(VW), .DW(DW), .OW(OW)) u_bank_ch1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (is_write && !addr_q[7]),
      .wr_idx    (idx),
      .wr_data   ({dhi_q, dlo_q}),
      .commit    (commit1),
      .step      (step_ch1),
      .init      (init_ch1),
      .offset    (offset_ch1),
      .prescaler (prescaler_ch1),
      .wavesel   (wavesel_ch1),
      .en        (ch1_en)
   );

   wavegen_cfg_bank #(.PW(PW), .VW(VW), .DW(DW), .OW(OW)) u_bank_ch2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (is_write && addr_q[7]),
      .wr_idx    (idx),
      .wr_data   ({dhi_q, dlo_q}),
      .commit    (commit2),
      .step      (step_ch2),
      .init      (init_ch2),
      .offset    (offset_ch2),
      .prescaler (prescaler_ch2),
      .wavesel   (wavesel_ch2),
      .en        (ch2_en)
   );

endmodule

// File: tb/tb_wavegen_cfg_ctrl.sv
// tb/tb_wavegen_cfg_ctrl.sv - directed table-driven bench for wavegen_cfg_ctrl
module tb_wavegen_cfg_ctrl;

   localparam int TMO = 16;
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [15:0] step_ch1, step_ch2, init_ch1, init_ch2;
   logic [11:0] offset_ch1, offset_ch2;
   logic [4:0]  prescaler_ch1, prescaler_ch2;
   logic [1:0]  wavesel_ch1, wavesel_ch2;
   logic        ch1_en, ch2_en;
   logic [1:0]  commit_pulse;
   logic [7:0]  err_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wavegen_cfg_ctrl #(.TO_W(5), .TIMEOUT(TMO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .step_ch1      (step_ch1),
      .step_ch2      (step_ch2),
      .init_ch1      (init_ch1),
      .init_ch2      (init_ch2),
      .offset_ch1    (offset_ch1),
      .offset_ch2    (offset_ch2),
      .prescaler_ch1 (prescaler_ch1),
      .prescaler_ch2 (prescaler_ch2),
      .wavesel_ch1   (wavesel_ch1),
      .wavesel_ch2   (wavesel_ch2),
      .ch1_en        (ch1_en),
      .ch2_en        (ch2_en),
      .commit_pulse  (commit_pulse),
      .err_count     (err_count)
   );

   typedef struct {
      logic [8:0]  pre;
      logic [39:0] frame;
      logic [7:0]  resp;
      logic [1:0]  pulse;
      logic [15:0] step1;
      logic [15:0] step2;
      logic [11:0] off2;
      logic [1:0]  en;
      logic [7:0]  err;
   } vec_t;

   vec_t vecs[10];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n == 100) chk("rx_accept", 32'(rx_ready), 32'd1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [39:0] frame);
      for (int i = 0; i < 5; i++) send_byte(frame[39 - 8*i -: 8]);
   endtask

   task automatic do_frame(input logic [39:0] frame, input logic [7:0] resp, input logic [1:0] pulse);
      send_frame(frame);
      chk("resp_early", 32'(tx_valid), 32'd0);
      @(negedge clk);
      chk("resp_valid", 32'(tx_valid), 32'd1);
      chk("resp_data", 32'(tx_data), 32'(resp));
      chk("commit_pulse", 32'(commit_pulse), 32'(pulse));
      chk("rx_ready_resp", 32'(rx_ready), 32'd0);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      chk("resp_done", 32'(tx_valid), 32'd0);
      chk("pulse_1cyc", 32'(commit_pulse), 32'd0);
   endtask

   initial begin
      int bad;
      vecs[0] = '{9'h000, 40'hA5_00_01_00_01, ACK, 2'b00, 16'h0000, 16'h0000, 12'h000, 2'b00, 8'd0};
      vecs[1] = '{9'h000, 40'hA5_06_00_00_06, ACK, 2'b01, 16'h0100, 16'h0000, 12'h000, 2'b00, 8'd0};
      vecs[2] = '{9'h000, 40'hA5_82_00_03_00, NAK, 2'b00, 16'h0100, 16'h0000, 12'h000, 2'b00, 8'd1};
      vecs[3] = '{9'h13C, 40'hA5_0A_00_00_0A, NAK, 2'b00, 16'h0100, 16'h0000, 12'h000, 2'b00, 8'd2};
      vecs[4] = '{9'h000, 40'hA5_10_00_00_10, NAK, 2'b00, 16'h0100, 16'h0000, 12'h000, 2'b00, 8'd3};
      vecs[5] = '{9'h000, 40'hA5_80_12_34_A6, ACK, 2'b00, 16'h0100, 16'h0000, 12'h000, 2'b00, 8'd3};
      vecs[6] = '{9'h000, 40'hA5_06_00_00_06, ACK, 2'b01, 16'h0100, 16'h0000, 12'h000, 2'b00, 8'd3};
      vecs[7] = '{9'h000, 40'hA5_05_00_01_04, ACK, 2'b00, 16'h0100, 16'h0000, 12'h000, 2'b00, 8'd3};
      vecs[8] = '{9'h000, 40'hA5_85_00_01_84, ACK, 2'b00, 16'h0100, 16'h0000, 12'h000, 2'b00, 8'd3};
      vecs[9] = '{9'h000, 40'hA5_07_00_00_07, ACK, 2'b11, 16'h0100, 16'h1234, 12'h000, 2'b11, 8'd3};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rx_ready_in_reset", 32'(rx_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_step_ch1", 32'(step_ch1), 32'd0);
      chk("rst_en", 32'({ch2_en, ch1_en}), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);
      chk("rst_rx_ready", 32'(rx_ready), 32'd1);

      for (int v = 0; v < 10; v++) begin
         if (vecs[v].pre[8]) send_byte(vecs[v].pre[7:0]);
         do_frame(vecs[v].frame, vecs[v].resp, vecs[v].pulse);
         chk($sformatf("v%0d_step1", v), 32'(step_ch1), 32'(vecs[v].step1));
         chk($sformatf("v%0d_step2", v), 32'(step_ch2), 32'(vecs[v].step2));
         chk($sformatf("v%0d_off2", v), 32'(offset_ch2), 32'(vecs[v].off2));
         chk($sformatf("v%0d_en", v), 32'({ch2_en, ch1_en}), 32'(vecs[v].en));
         chk($sformatf("v%0d_err", v), 32'(err_count), 32'(vecs[v].err));
      end

      // Inter-byte timeout: abort lands exactly TMO edges after the last byte
      send_byte(8'hA5);
      send_byte(8'h01);
      repeat (TMO - 1) @(negedge clk);
      chk("tmo_not_yet_err", 32'(err_count), 32'd3);
      chk("tmo_not_yet_ready", 32'(rx_ready), 32'd1);
      @(negedge clk);
      chk("tmo_err", 32'(err_count), 32'd4);
      chk("tmo_no_tx", 32'(tx_valid), 32'd0);
      do_frame(40'hA5_01_00_05_04, ACK, 2'b00);
      chk("tmo_after_err", 32'(err_count), 32'd4);

      // Response stall with a byte waiting at the input
      send_frame(40'hA5_02_0A_BC_B4);
      @(negedge clk);
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         if (tx_valid !== 1'b1 || tx_data !== ACK || rx_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      chk("stall_stable", 32'(bad), 32'd0);
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      chk("stall_release_valid", 32'(tx_valid), 32'd0);
      chk("stall_release_ready", 32'(rx_ready), 32'd1);
      chk("stall_err", 32'(err_count), 32'd4);

      do_frame(40'hA5_06_00_00_06, ACK, 2'b01);
      chk("commit_offset1", 32'(offset_ch1), 32'hABC);
      chk("commit_init1", 32'(init_ch1), 32'd5);

      // Mid-frame reset
      send_byte(8'hA5);
      send_byte(8'h02);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_step1", 32'(step_ch1), 32'd0);
      chk("mrst_step2", 32'(step_ch2), 32'd0);
      chk("mrst_init1", 32'(init_ch1), 32'd0);
      chk("mrst_offset1", 32'(offset_ch1), 32'd0);
      chk("mrst_en", 32'({ch2_en, ch1_en}), 32'd0);
      chk("mrst_err", 32'(err_count), 32'd0);
      chk("mrst_tx_valid", 32'(tx_valid), 32'd0);
      chk("mrst_tx_data", 32'(tx_data), 32'd0);
      chk("mrst_pulse", 32'(commit_pulse), 32'd0);
      chk("mrst_rx_ready", 32'(rx_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      do_frame(40'hA5_00_00_07_07, ACK, 2'b00);
      chk("post_rst_err", 32'(err_count), 32'd0);
      chk("post_rst_shadow_only", 32'(step_ch1), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
